qeciphy_tx_word_scheduler: RTL and testbench
============================================

// Module: qeciphy_tx_word_scheduler
// PURPOSE
//  Sequences the 64-bit TX word stream feeding the TX 64b->32b width converter.
//  Each word slot (two clk_i cycles) carries exactly one of three words: a periodic
//  FAW, a user data word from an AXI-Stream-style source, or an idle fill word.
//  Loads are aligned to the converter's lower/upper phase, so the converter never
//  sees a word change mid-slot.
// PARAMETERS
//  FAW_PERIOD  64                     slots per frame, FAW slot included; legal range 2..65535
//  FAW_WORD    64'h0000_0000_0000_00BC  frame alignment word (K28.5 in byte 0)
//  IDLE_WORD   64'h0000_0000_0000_0000  fill word for slots with no data
// PORTS
//  clk_i               in   1   clock (converter clock)
//  rst_n_i             in   1   reset, asynchronous, active-low
//  enable_i            in   1   1 = framed transmission, 0 = idle fill only
//  s_tdata_i           in   64  user data word
//  s_tvalid_i          in   1   s_tdata_i valid
//  s_tready_o          out  1   data word accepted this cycle (valid & ready)
//  tdata_64b_o         out  64  word to converter, stable for a whole slot
//  tdata_64b_isfaw_o   out  1   tdata_64b_o is FAW_WORD
//  slot_phase_o        out  1   internal phase; 0 = converter takes lower half next edge
//  frame_start_o       out  1   1-cycle pulse when a FAW is loaded
//  data_cnt_o          out  32  data words accepted since reset (wraps)
// BEHAVIOUR
//  Reset (async assert, sync release): phase=0, slot_cnt=0, state=DISABLED,
//   tdata_64b_o=IDLE_WORD, isfaw=0, s_tready_o=0, frame_start_o=0, data_cnt_o=0.
//  Phase: toggles every cycle from reset. Released in the same cycle as the
//   converter reset, it tracks the converter's cycle bit exactly.
//  Load edge: only on an edge with phase==1. The word then holds for the
//   cycle-0 (lower) and cycle-1 (upper) samples that follow. No output word
//   or isfaw change at any other edge.
//  FSM, evaluated on load edges only:
//   DISABLED: load IDLE_WORD; slot_cnt held at 0.
//             Moves to RUN when enable_i=1, and the next load is FAW.
//   RUN: slot_cnt==0 -> load FAW_WORD, set isfaw=1, pulse frame_start_o.
//        Otherwise, if s_tvalid_i -> load s_tdata_i and accept it;
//        otherwise -> load IDLE_WORD.
//        slot_cnt <= (slot_cnt==FAW_PERIOD-1) ? 0 : slot_cnt+1.
//        enable_i=0 sampled -> this slot loads IDLE_WORD, go to DISABLED, slot_cnt=0.
//  Transition timing: enable_i is sampled only at load edges. The first slot
//   after enable rises is FAW (latency from enable rise to FAW on tdata_64b_o:
//   1..2 cycles). A FAW already loaded is always completed.
//  Handshake: s_tready_o is combinational: phase==1 & state RUN & enable_i &
//   slot_cnt!=0. Data transfers when s_tvalid_i & s_tready_o.
//   - The source holds tdata and valid until the transfer.
//   - FAW slots stall the source; it is never dropped.
//   - s_tvalid_i low in a data slot inserts idle; no bubble is carried forward.
//  data_cnt_o increments by 1 per transfer and wraps modulo 2^32.
//  Reset mid-slot: all state returns to reset values immediately, and any
//   in-flight word is discarded.
// TESTING
//  1. Reset, enable_i=0 for 20 cycles -> tdata_64b_o=IDLE_WORD, isfaw=0,
//     s_tready_o=0, phase alternates 0,1,...
//  2. FAW_PERIOD=4, enable_i=1, s_tvalid_i=1, data 1,2,3,... -> slot words
//     FAW,1,2,3,FAW,4,5,6; frame_start_o pulses every 8 cycles; data_cnt_o=6.
//  3. FAW_PERIOD=4, s_tvalid_i=0 in slot 2 only -> slots FAW,1,IDLE,2,FAW;
//     word 2 held by the source and accepted exactly once.
//  4. Deassert enable_i during a data slot -> that word completes, the next slot
//     is IDLE. Re-enable -> the next slot is FAW and slot_cnt restarts at 1.
//  5. Chain with the 64b->32b converter; check 32b stream
//     = {FAW[31:0],FAW[63:32],d[31:0],d[63:32],...} with charisk=4'b0001 only
//     on the FAW lower half.
//  6. Assert rst_n_i low mid-slot -> all outputs at reset values asynchronously;
//     after release the first enabled slot is FAW.

Source files
------------

// File: rtl/qeciphy_tx_word_scheduler.sv
// -----------------------------------------------------------------------------
// qeciphy_tx_word_scheduler
//
// Purpose:
//   Builds the 64-bit TX word stream that feeds the 64b->32b width converter.
//   Each word slot lasts two clk_i cycles. A slot carries one of three words:
//   the periodic frame alignment word (FAW), a user data word, or an idle fill
//   word. A new word is loaded only on the edge that closes a slot, which is
//   the edge where the converter takes the upper half. The converter therefore
//   never sees the word change in the middle of a slot.
//
// Ports:
//   clk_i             in   1   converter clock
//   rst_n_i           in   1   asynchronous active-low reset
//   enable_i          in   1   1 = framed transmission, 0 = idle fill only
//   s_tdata_i         in   64  user data word
//   s_tvalid_i        in   1   s_tdata_i is valid
//   s_tready_o        out  1   data word is taken this cycle (combinational)
//   tdata_64b_o       out  64  word to the converter, stable for a whole slot
//   tdata_64b_isfaw_o out  1   tdata_64b_o holds FAW_WORD
//   slot_phase_o      out  1   0 = the converter takes the lower half next edge
//   frame_start_o     out  1   one-cycle pulse when a FAW is loaded
//   data_cnt_o        out  32  data words accepted since reset (wraps)
// -----------------------------------------------------------------------------
module qeciphy_tx_word_scheduler #(
  parameter int unsigned FAW_PERIOD = 64,  // slots per frame, FAW included; 2..65535
  parameter logic [63:0] FAW_WORD   = 64'h0000_0000_0000_00BC,
  parameter logic [63:0] IDLE_WORD  = 64'h0000_0000_0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [63:0] s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  output logic [63:0] tdata_64b_o,
  output logic        tdata_64b_isfaw_o,
  output logic        slot_phase_o,
  output logic        frame_start_o,
  output logic [31:0] data_cnt_o
);

  typedef enum logic [0:0] {
    ST_DISABLED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  localparam logic [15:0] LAST_SLOT = 16'(FAW_PERIOD - 1);

  state_t      r_state;
  logic        r_phase;
  logic [15:0] r_slot_cnt;
  logic [63:0] r_tdata;
  logic        r_isfaw;
  logic        r_frame_start;
  logic [31:0] r_data_cnt;

  logic        w_ready;
  logic        w_take;
  logic [15:0] w_slot_next;

  // Handshake and slot counter next value.
  always_comb begin
    w_ready = 1'b0;
    if (r_phase && (r_state == ST_RUN) && enable_i && (r_slot_cnt != 16'd0)) begin
      w_ready = 1'b1;
    end else begin
      w_ready = 1'b0;
    end
    w_take = w_ready & s_tvalid_i;
    if (r_slot_cnt == LAST_SLOT) begin
      w_slot_next = 16'd0;
    end else begin
      w_slot_next = r_slot_cnt + 16'd1;
    end
  end

  // Phase tracker, slot FSM and word/flag registers; the FSM moves only on load edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_phase       <= 1'b0;
      r_state       <= ST_DISABLED;
      r_slot_cnt    <= 16'd0;
      r_tdata       <= IDLE_WORD;
      r_isfaw       <= 1'b0;
      r_frame_start <= 1'b0;
      r_data_cnt    <= 32'd0;
    end else begin
      r_phase       <= ~r_phase;
      r_frame_start <= 1'b0;
      if (r_phase) begin
        case (r_state)
          ST_DISABLED: begin
            if (enable_i) begin
              // The slot that follows enable is the FAW itself, so the
              // counter continues from slot 1 (FAW_PERIOD is at least 2).
              r_state       <= ST_RUN;
              r_tdata       <= FAW_WORD;
              r_isfaw       <= 1'b1;
              r_frame_start <= 1'b1;
              r_slot_cnt    <= 16'd1;
            end else begin
              r_tdata    <= IDLE_WORD;
              r_isfaw    <= 1'b0;
              r_slot_cnt <= 16'd0;
            end
          end
          ST_RUN: begin
            if (!enable_i) begin
              r_state    <= ST_DISABLED;
              r_tdata    <= IDLE_WORD;
              r_isfaw    <= 1'b0;
              r_slot_cnt <= 16'd0;
            end else begin
              if (r_slot_cnt == 16'd0) begin
                r_tdata       <= FAW_WORD;
                r_isfaw       <= 1'b1;
                r_frame_start <= 1'b1;
              end else if (w_take) begin
                r_tdata <= s_tdata_i;
                r_isfaw <= 1'b0;
              end else begin
                r_tdata <= IDLE_WORD;
                r_isfaw <= 1'b0;
              end
              r_slot_cnt <= w_slot_next;
            end
          end
          default: begin
            r_state    <= ST_DISABLED;
            r_tdata    <= IDLE_WORD;
            r_isfaw    <= 1'b0;
            r_slot_cnt <= 16'd0;
          end
        endcase
      end
      if (w_take) begin
        r_data_cnt <= r_data_cnt + 32'd1;
      end
    end
  end

  assign s_tready_o        = w_ready;
  assign tdata_64b_o       = r_tdata;
  assign tdata_64b_isfaw_o = r_isfaw;
  assign slot_phase_o      = r_phase;
  assign frame_start_o     = r_frame_start;
  assign data_cnt_o        = r_data_cnt;

endmodule

// File: tb/tb_qeciphy_tx_word_scheduler.sv
// -----------------------------------------------------------------------------
// tb_qeciphy_tx_word_scheduler
//
// Directed bench for the TX word scheduler with FAW_PERIOD=4. A vector table
// covers framing, data stalls in FAW slots, idle insertion and enable
// toggling. Hand sequences cover the reset state, a downstream 64b->32b
// converter stream and an asynchronous reset in the middle of a slot.
// -----------------------------------------------------------------------------
module tb_qeciphy_tx_word_scheduler;

  localparam logic [63:0] F = 64'h0000_0000_0000_00BC;
  localparam logic [63:0] I = 64'h0000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] sdata;
  logic        svalid;
  logic        sready;
  logic [63:0] word;
  logic        isfaw;
  logic        phase;
  logic        fstart;
  logic [31:0] dcnt;

  logic [31:0] conv_d;
  logic [3:0]  conv_k;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qeciphy_tx_word_scheduler #(.FAW_PERIOD(4)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .enable_i          (en),
    .s_tdata_i         (sdata),
    .s_tvalid_i        (svalid),
    .s_tready_o        (sready),
    .tdata_64b_o       (word),
    .tdata_64b_isfaw_o (isfaw),
    .slot_phase_o      (phase),
    .frame_start_o     (fstart),
    .data_cnt_o        (dcnt)
  );

  // Downstream width converter: lower half when phase is 0, upper half when 1.
  always_ff @(posedge clk) begin
    conv_d <= phase ? word[63:32] : word[31:0];
    conv_k <= (!phase && isfaw) ? 4'b0001 : 4'b0000;
  end

  function automatic logic [63:0] dw(input int n);
    dw = {32'hC0DE_0000 | 32'(n), 32'hA5A5_0000 | 32'(n)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic        v;
    logic [63:0] d;
    logic        e_rdy;
    logic [63:0] e_w;
    logic        e_faw;
    logic        e_fs;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic v, input logic [63:0] d,
                              input logic r, input logic [63:0] w, input logic f,
                              input logic fs, input int c);
    mk.en = e; mk.v = v; mk.d = d; mk.e_rdy = r;
    mk.e_w = w; mk.e_faw = f; mk.e_fs = fs; mk.e_cnt = 32'(c);
  endfunction

  vec_t vecs [34];

  initial begin
    logic [63:0] exp_w [8];
    int src;

    // Each row: inputs for one cycle, expected ready during that cycle,
    // expected registered outputs after the following rising edge.
    vecs[0]  = mk(1'b1, 1'b1, dw(1),  1'b0, I,      1'b0, 1'b0, 0);
    vecs[1]  = mk(1'b1, 1'b1, dw(1),  1'b0, F,      1'b1, 1'b1, 0);
    vecs[2]  = mk(1'b1, 1'b1, dw(1),  1'b0, F,      1'b1, 1'b0, 0);
    vecs[3]  = mk(1'b1, 1'b1, dw(1),  1'b1, dw(1),  1'b0, 1'b0, 1);
    vecs[4]  = mk(1'b1, 1'b1, dw(2),  1'b0, dw(1),  1'b0, 1'b0, 1);
    vecs[5]  = mk(1'b1, 1'b1, dw(2),  1'b1, dw(2),  1'b0, 1'b0, 2);
    vecs[6]  = mk(1'b1, 1'b1, dw(3),  1'b0, dw(2),  1'b0, 1'b0, 2);
    vecs[7]  = mk(1'b1, 1'b1, dw(3),  1'b1, dw(3),  1'b0, 1'b0, 3);
    vecs[8]  = mk(1'b1, 1'b1, dw(4),  1'b0, dw(3),  1'b0, 1'b0, 3);
    vecs[9]  = mk(1'b1, 1'b1, dw(4),  1'b0, F,      1'b1, 1'b1, 3);
    vecs[10] = mk(1'b1, 1'b1, dw(4),  1'b0, F,      1'b1, 1'b0, 3);
    vecs[11] = mk(1'b1, 1'b1, dw(4),  1'b1, dw(4),  1'b0, 1'b0, 4);
    vecs[12] = mk(1'b1, 1'b1, dw(5),  1'b0, dw(4),  1'b0, 1'b0, 4);
    vecs[13] = mk(1'b1, 1'b1, dw(5),  1'b1, dw(5),  1'b0, 1'b0, 5);
    vecs[14] = mk(1'b1, 1'b1, dw(6),  1'b0, dw(5),  1'b0, 1'b0, 5);
    vecs[15] = mk(1'b1, 1'b1, dw(6),  1'b1, dw(6),  1'b0, 1'b0, 6);
    vecs[16] = mk(1'b1, 1'b0, I,      1'b0, dw(6),  1'b0, 1'b0, 6);
    vecs[17] = mk(1'b1, 1'b0, I,      1'b0, F,      1'b1, 1'b1, 6);
    vecs[18] = mk(1'b1, 1'b1, dw(7),  1'b0, F,      1'b1, 1'b0, 6);
    vecs[19] = mk(1'b1, 1'b1, dw(7),  1'b1, dw(7),  1'b0, 1'b0, 7);
    vecs[20] = mk(1'b1, 1'b0, I,      1'b0, dw(7),  1'b0, 1'b0, 7);
    vecs[21] = mk(1'b1, 1'b0, I,      1'b1, I,      1'b0, 1'b0, 7);
    vecs[22] = mk(1'b1, 1'b1, dw(8),  1'b0, I,      1'b0, 1'b0, 7);
    vecs[23] = mk(1'b1, 1'b1, dw(8),  1'b1, dw(8),  1'b0, 1'b0, 8);
    vecs[24] = mk(1'b1, 1'b1, dw(9),  1'b0, dw(8),  1'b0, 1'b0, 8);
    vecs[25] = mk(1'b1, 1'b1, dw(9),  1'b0, F,      1'b1, 1'b1, 8);
    vecs[26] = mk(1'b1, 1'b1, dw(9),  1'b0, F,      1'b1, 1'b0, 8);
    vecs[27] = mk(1'b1, 1'b1, dw(9),  1'b1, dw(9),  1'b0, 1'b0, 9);
    vecs[28] = mk(1'b0, 1'b1, dw(10), 1'b0, dw(9),  1'b0, 1'b0, 9);
    vecs[29] = mk(1'b0, 1'b1, dw(10), 1'b0, I,      1'b0, 1'b0, 9);
    vecs[30] = mk(1'b0, 1'b1, dw(10), 1'b0, I,      1'b0, 1'b0, 9);
    vecs[31] = mk(1'b1, 1'b1, dw(10), 1'b0, F,      1'b1, 1'b1, 9);
    vecs[32] = mk(1'b1, 1'b1, dw(10), 1'b0, F,      1'b1, 1'b0, 9);
    vecs[33] = mk(1'b1, 1'b1, dw(10), 1'b1, dw(10), 1'b0, 1'b0, 10);

    rst_n = 1'b0; en = 1'b0; svalid = 1'b0; sdata = 64'd0;

    // Reset state.
    @(negedge clk);
    chk("rst_word", word, I);
    chk("rst_isfaw", {63'd0, isfaw}, 64'd0);
    chk("rst_ready", {63'd0, sready}, 64'd0);
    chk("rst_fstart", {63'd0, fstart}, 64'd0);
    chk("rst_phase", {63'd0, phase}, 64'd0);
    chk("rst_dcnt", {32'd0, dcnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled: idle fill, phase alternates 1,0,1,... after each edge.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("dis_word", word, I);
      chk("dis_isfaw", {63'd0, isfaw}, 64'd0);
      chk("dis_ready", {63'd0, sready}, 64'd0);
      chk("dis_phase", {63'd0, phase}, 64'(i % 2));
    end

    // Table: framing, FAW stall, idle insertion, enable off/on.
    for (int i = 0; i < 34; i++) begin
      en = vecs[i].en; svalid = vecs[i].v; sdata = vecs[i].d;
      #1;
      chk($sformatf("v%0d_ready", i), {63'd0, sready}, {63'd0, vecs[i].e_rdy});
      @(negedge clk);
      chk($sformatf("v%0d_word", i), word, vecs[i].e_w);
      chk($sformatf("v%0d_isfaw", i), {63'd0, isfaw}, {63'd0, vecs[i].e_faw});
      chk($sformatf("v%0d_fstart", i), {63'd0, fstart}, {63'd0, vecs[i].e_fs});
      chk($sformatf("v%0d_phase", i), {63'd0, phase}, 64'((i + 1) % 2 == 0 ? 0 : 1) ^ 64'd0);
      chk($sformatf("v%0d_dcnt", i), {32'd0, dcnt}, {32'd0, vecs[i].e_cnt});
    end

    // Converter stream: d10 lo/hi, d11 lo/hi, d12 lo/hi, FAW lo (K) / hi.
    exp_w[0] = dw(10); exp_w[1] = dw(10); exp_w[2] = dw(11); exp_w[3] = dw(11);
    exp_w[4] = dw(12); exp_w[5] = dw(12); exp_w[6] = F;      exp_w[7] = F;
    src = 11;
    for (int j = 0; j < 8; j++) begin
      en = 1'b1; svalid = 1'b1; sdata = dw(src);
      #1;
      if (sready) src++;
      @(negedge clk);
      chk($sformatf("conv%0d_data", j), {32'd0, conv_d},
          {32'd0, (j % 2 == 0) ? exp_w[j][31:0] : exp_w[j][63:32]});
      chk($sformatf("conv%0d_k", j), {60'd0, conv_k}, (j == 6) ? 64'd1 : 64'd0);
    end
    chk("conv_dcnt", {32'd0, dcnt}, 64'd13);

    // Asynchronous reset in the middle of a slot, then enabled restart.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_word", word, I);
    chk("arst_isfaw", {63'd0, isfaw}, 64'd0);
    chk("arst_phase", {63'd0, phase}, 64'd0);
    chk("arst_ready", {63'd0, sready}, 64'd0);
    chk("arst_dcnt", {32'd0, dcnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; svalid = 1'b1; sdata = dw(20);
    @(negedge clk);
    chk("rel_word0", word, I);
    chk("rel_phase0", {63'd0, phase}, 64'd1);
    @(negedge clk);
    chk("rel_word1", word, F);
    chk("rel_isfaw1", {63'd0, isfaw}, 64'd1);
    chk("rel_fstart1", {63'd0, fstart}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
